hv_bundler: RTL

HV_BUNDLER -- requirements
Module: hv_bundler

---
 rtl/hdc_pkg.sv | 13 +
 rtl/hv_bundler_if.sv | 29 ++
 rtl/bundle_counter_bank.sv | 52 +++++
 rtl/hv_bundler.sv | 123 ++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared defaults and state encoding for the hypervector bundler.
// Optional feature macro: HV_BUNDLER_TIE_BREAK_EN (ties resolved by the first vector of the bundle).
package hdc_pkg;

    localparam int unsigned DIM_DEFAULT   = 1023;
    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_e;

endpackage

// File: rtl/hv_bundler_if.sv
// Input/output handshake bundle of hv_bundler; master = upstream/downstream side, slave = bundler.
interface hv_bundler_if
    import hdc_pkg::*;
#(
    parameter int unsigned DIM   = DIM_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
);

    logic             in_valid;
    logic [DIM:0]     in_hv;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [DIM:0]     out_hv;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport master (
        output in_valid, in_hv, in_last, out_ready,
        input  in_ready, out_valid, out_hv, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_hv, in_last, out_ready,
        output in_ready, out_valid, out_hv, out_count, out_sat
    );

endinterface

// File: rtl/bundle_counter_bank.sv
// Per-bit ones counters with clear/increment and the majority threshold compare.
// Optional feature macro: HV_BUNDLER_TIE_BREAK_EN (exposes the per-bit tie vector).
module bundle_counter_bank
    import hdc_pkg::*;
#(
    parameter int unsigned DIM   = DIM_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc_en,
    input  logic [DIM:0]     hv_i,
    input  logic [CNT_W-1:0] n_i,
    output logic [DIM:0]     maj_o
`ifdef HV_BUNDLER_TIE_BREAK_EN
    ,
    output logic [DIM:0]     tie_o
`endif
);

    logic [CNT_W-1:0] cnt_q  [DIM+1];
    logic [CNT_W-1:0] cnt_d  [DIM+1];
    logic [CNT_W-1:0] cnt_nx [DIM+1];

    // Compare uses the post-increment count against the post-increment N, widened by one bit.
    always_comb begin
        maj_o = '0;
`ifdef HV_BUNDLER_TIE_BREAK_EN
        tie_o = '0;
`endif
        for (int unsigned i = 0; i <= DIM; i++) begin
            cnt_nx[i] = cnt_q[i] + CNT_W'(inc_en && hv_i[i]);
            cnt_d[i]  = clr ? '0 : cnt_nx[i];
            maj_o[i]  = {cnt_nx[i], 1'b0} > {1'b0, n_i};
`ifdef HV_BUNDLER_TIE_BREAK_EN
            tie_o[i]  = {cnt_nx[i], 1'b0} == {1'b0, n_i};
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i <= DIM; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hv_bundler.sv
// Majority bundler: accumulates accepted hypervectors, presents the per-bit majority on close.
// Optional feature macro: HV_BUNDLER_TIE_BREAK_EN (ties take the bundle's first vector bit).
module hv_bundler
    import hdc_pkg::*;
#(
    parameter int unsigned DIM   = DIM_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    hv_bundler_if.slave  bus
);

    localparam logic [CNT_W-1:0] N_LIMIT = {{(CNT_W-1){1'b1}}, 1'b0};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [DIM:0]     out_hv_q, out_hv_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_sat_q, out_sat_d;

    logic             accept;
    logic             handoff;
    logic             close;
    logic [CNT_W-1:0] n_inc;
    logic [DIM:0]     maj;
    logic [DIM:0]     hv_next;

    assign accept  = bus.in_valid && (state_q == ACC);
    assign handoff = bus.out_ready && (state_q == OUT);
    assign n_inc   = n_q + 1'b1;
    assign close   = accept && (bus.in_last || (n_q == N_LIMIT));

`ifdef HV_BUNDLER_TIE_BREAK_EN
    logic [DIM:0] tie;
    logic [DIM:0] first_q, first_d;

    // The first vector is still on in_hv when it is also the closing vector.
    assign first_d = (accept && (n_q == '0)) ? bus.in_hv : first_q;
    assign hv_next = maj | (tie & ((n_q == '0) ? bus.in_hv : first_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= '0;
        end else begin
            first_q <= first_d;
        end
    end
`else
    assign hv_next = maj;
`endif

    bundle_counter_bank #(
        .DIM   (DIM),
        .CNT_W (CNT_W)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .clr    (handoff),
        .inc_en (accept),
        .hv_i   (bus.in_hv),
        .n_i    (n_inc),
        .maj_o  (maj)
`ifdef HV_BUNDLER_TIE_BREAK_EN
        ,
        .tie_o  (tie)
`endif
    );

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        out_hv_d    = out_hv_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        unique case (state_q)
            ACC: begin
                if (accept) begin
                    n_d = n_inc;
                end
                if (close) begin
                    state_d     = OUT;
                    out_hv_d    = hv_next;
                    out_count_d = n_inc;
                    out_sat_d   = !bus.in_last;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d     = ACC;
                    n_d         = '0;
                    out_hv_d    = '0;
                    out_count_d = '0;
                    out_sat_d   = 1'b0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            n_q         <= '0;
            out_hv_q    <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            out_hv_q    <= out_hv_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_hv    = out_hv_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;

endmodule
